// File: rtl/hub75_scan.sv
// HUB75 LED panel scan controller: shifts one bitplane per scan row, latches, then displays a BCM-weighted slot.
// Optional macro HUB75_BRIGHTNESS_EN adds brightness[7:0], which trims the lit part of each display slot.
module hub75_scan #(
    parameter int unsigned PANEL_COLS  = 64,
    parameter int unsigned ROW_BITS    = 5,
    parameter int unsigned BCM_BITS    = 8,
    parameter int unsigned BASE_CYCLES = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   enable,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]                             brightness,
`endif
    output logic                                   mem_re,
    output logic [ROW_BITS+$clog2(PANEL_COLS)-1:0] mem_addr,
    input  logic [63:0]                            mem_dout,
    output logic                                   r0,
    output logic                                   g0,
    output logic                                   b0,
    output logic                                   r1,
    output logic                                   g1,
    output logic                                   b1,
    output logic                                   panel_clk,
    output logic                                   lat,
    output logic                                   oe_n,
    output logic [ROW_BITS-1:0]                    row_addr,
    output logic                                   frame_done
);

    localparam int unsigned COL_W     = $clog2(PANEL_COLS);
    localparam int unsigned SHIFT_LEN = 2 * PANEL_COLS + 2;
    localparam int unsigned SLOT_MAX  = BASE_CYCLES << (BCM_BITS - 1);
    localparam int unsigned CNT_W     = $clog2(((SHIFT_LEN > SLOT_MAX) ? SHIFT_LEN : SLOT_MAX) + 1);
    localparam int unsigned BIT_W     = (BCM_BITS > 1) ? $clog2(BCM_BITS) : 1;

    typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_BLANK, ST_LATCH, ST_DISPLAY} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BIT_W-1:0]    bit_q;
    logic [ROW_BITS-1:0] row_q;

    logic [CNT_W-1:0]    cnt_d;
    logic [BIT_W-1:0]    bit_d;
    logic [ROW_BITS-1:0] row_d;
    logic                last_bit;
    logic                last_row;
    logic [CNT_W-1:0]    slot_len;
    logic [CNT_W-1:0]    on_len;
    logic [2:0]          bsel;
    logic [7:0]          r_up, g_up, b_up, r_lo, g_lo, b_lo;
    logic                unused_dout;

    assign cnt_d    = cnt_q + CNT_W'(1);
    assign last_bit = (bit_q == BIT_W'(BCM_BITS - 1));
    assign last_row = &row_q;
    assign bit_d    = last_bit ? '0 : bit_q + BIT_W'(1);
    assign row_d    = last_bit ? row_q + ROW_BITS'(1) : row_q;
    assign slot_len = CNT_W'(BASE_CYCLES) << bit_q;

`ifdef HUB75_BRIGHTNESS_EN
    localparam int unsigned PROD_W = CNT_W + 9;
    // Lit portion scales with (brightness+1)/256; slot length is unchanged.
    assign on_len = CNT_W'((PROD_W'(slot_len) * PROD_W'(brightness) + PROD_W'(slot_len)) >> 8);
`else
    assign on_len = slot_len;
`endif

    assign bsel = 3'(bit_q);
    assign r_up = mem_dout[23:16];
    assign g_up = mem_dout[15:8];
    assign b_up = mem_dout[7:0];
    assign r_lo = mem_dout[55:48];
    assign g_lo = mem_dout[47:40];
    assign b_lo = mem_dout[39:32];
    assign unused_dout = ^{mem_dout[63:56], mem_dout[31:24]};

    // Scan FSM; every output is registered and describes the cycle following each edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            row_q      <= '0;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            {r0, g0, b0, r1, g1, b1} <= 6'b0;
            panel_clk  <= 1'b0;
            lat        <= 1'b0;
            oe_n       <= 1'b1;
            row_addr   <= '0;
            frame_done <= 1'b0;
        end else begin
            mem_re     <= 1'b0;
            panel_clk  <= 1'b0;
            lat        <= 1'b0;
            oe_n       <= 1'b1;
            frame_done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q  <= ST_SHIFT;
                        cnt_q    <= '0;
                        bit_q    <= '0;
                        row_q    <= '0;
                        mem_re   <= 1'b1;
                        mem_addr <= '0;
                    end
                end
                ST_SHIFT: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == CNT_W'(SHIFT_LEN - 1)) begin
                        state_q <= ST_BLANK;
                    end else begin
                        // Even cycles: issue next read and present the pixel read two cycles ago.
                        if (!cnt_d[0]) begin
                            {r0, g0, b0} <= {r_up[bsel], g_up[bsel], b_up[bsel]};
                            {r1, g1, b1} <= {r_lo[bsel], g_lo[bsel], b_lo[bsel]};
                            if (cnt_d <= CNT_W'(2 * PANEL_COLS - 2)) begin
                                mem_re   <= 1'b1;
                                mem_addr <= {row_q, COL_W'(cnt_d >> 1)};
                            end
                        end else if (cnt_d >= CNT_W'(3)) begin
                            panel_clk <= 1'b1;
                        end
                    end
                end
                ST_BLANK: begin
                    state_q  <= ST_LATCH;
                    lat      <= 1'b1;
                    row_addr <= row_q;
                end
                ST_LATCH: begin
                    state_q <= ST_DISPLAY;
                    cnt_q   <= '0;
                    oe_n    <= (on_len == '0);
                end
                ST_DISPLAY: begin
                    if (cnt_q == slot_len - CNT_W'(1)) begin
                        bit_q      <= bit_d;
                        row_q      <= row_d;
                        frame_done <= last_bit && last_row;
                        cnt_q      <= '0;
                        if (last_bit && last_row && !enable) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q  <= ST_SHIFT;
                            mem_re   <= 1'b1;
                            mem_addr <= {row_d, {COL_W{1'b0}}};
                        end
                    end else begin
                        cnt_q <= cnt_d;
                        oe_n  <= !(cnt_d < on_len);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_scan.sv
// Directed bench for hub75_scan on a 4-column, 2-row, 2-bitplane panel with a framebuffer model
// and an ordered scoreboard of expected panel events (shift pulses, latches, display runs, frame ends).
module tb_hub75_scan;

    localparam int unsigned COLS = 4;
    localparam int unsigned RB   = 1;
    localparam int unsigned BCM  = 2;
    localparam int unsigned BASE = 2;
    localparam int unsigned AW   = 3;

    localparam logic [3:0] K_CLK = 4'd1;
    localparam logic [3:0] K_LAT = 4'd2;
    localparam logic [3:0] K_OE  = 4'd3;
    localparam logic [3:0] K_FD  = 4'd4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_dout = 64'd0;
    logic          r0, g0, b0, r1, g1, b1;
    logic          panel_clk, lat, oe_n;
    logic [RB-1:0] row_addr;
    logic          frame_done;
`ifdef HUB75_BRIGHTNESS_EN
    logic [7:0]    brightness = 8'd127;
`endif

    hub75_scan #(.PANEL_COLS(COLS), .ROW_BITS(RB), .BCM_BITS(BCM), .BASE_CYCLES(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
        .panel_clk(panel_clk), .lat(lat), .oe_n(oe_n),
        .row_addr(row_addr), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [63:0] fb [8];
    always @(posedge clk) if (mem_re) mem_dout <= fb[mem_addr];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          fd_seen  = 0;
    int          run      = 0;
    logic        mon_en   = 1'b0;
    logic [5:0]  prev_rgb = 6'd0;
    logic [15:0] ev_q[$];
    logic [AW-1:0] addr_q[$];
    logic [31:0] m_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int unsigned oe_len(input int unsigned b);
`ifdef HUB75_BRIGHTNESS_EN
        return ((BASE << b) * (int'(brightness) + 1)) >> 8;
`else
        return BASE << b;
`endif
    endfunction

    task automatic check_ev(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        e = (ev_q.size() != 0) ? ev_q.pop_front() : 16'hFFFF;
        check(tag, 32'(obs), 32'(e));
    endtask

    // Expected events for one full frame, in the order the panel should see them.
    task automatic push_frame();
        for (int row = 0; row < 2; row++) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < 4; c++) begin
                    logic [63:0] w;
                    w = fb[row*4+c];
                    addr_q.push_back(AW'(row*4+c));
                    ev_q.push_back({K_CLK, 6'd0, w[16+b], w[8+b], w[b], w[48+b], w[40+b], w[32+b]});
                end
                ev_q.push_back({K_LAT, 12'(row)});
                if (oe_len(b) != 0) ev_q.push_back({K_OE, 12'(oe_len(b))});
                if (row == 1 && b == 1) ev_q.push_back({K_FD, 12'd0});
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_oe_n"}, 32'(oe_n), 32'd1);
        check({tag, "_outs"}, 32'({mem_re, mem_addr, r0, g0, b0, r1, g1, b1, panel_clk, lat, row_addr, frame_done}), 32'd0);
    endtask

    task automatic wait_fd(input int n, input int budget);
        for (int i = 0; i < budget && fd_seen < n; i++) @(negedge clk);
        check("frame_done_count", 32'(fd_seen), 32'(n));
    endtask

    // Panel-side monitor: turns output activity into events and pops the scoreboard.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (mem_re) begin
                m_exp = (addr_q.size() != 0) ? 32'(addr_q.pop_front()) : 32'hFFFF_FFFF;
                check("mem_addr", 32'(mem_addr), m_exp);
                check("oe_n_during_read", 32'(oe_n), 32'd1);
            end
            if (panel_clk) begin
                check("rgb_stable_at_clk", 32'({r0, g0, b0, r1, g1, b1}), 32'(prev_rgb));
                check_ev("ev_clk", {K_CLK, 6'd0, r0, g0, b0, r1, g1, b1});
            end
            if (!oe_n) begin
                run++;
            end else if (run != 0) begin
                check_ev("ev_oe_run", {K_OE, 12'(run)});
                run = 0;
            end
            if (lat) check_ev("ev_lat", {K_LAT, 12'(row_addr)});
            if (frame_done) begin
                fd_seen++;
                check_ev("ev_frame_done", {K_FD, 12'd0});
            end
        end else begin
            run = 0;
        end
        prev_rgb = {r0, g0, b0, r1, g1, b1};
    end

    initial begin
        int pc;
        fb[0] = 64'h00A5_5A3C_00C3_3CF0;
        fb[1] = 64'h0001_0203_0002_0101;
        fb[2] = 64'h00FF_0000_0000_FF00;
        fb[3] = 64'h0000_00FF_00FF_FFFF;
        fb[4] = 64'h0003_0102_0001_0203;
        fb[5] = 64'h0002_0002_0003_0000;
        fb[6] = 64'h0000_0301_0102_0300;
        fb[7] = 64'h0001_0101_0002_0202;

        rst_n = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");

        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_oe_n", 32'(oe_n), 32'd1);
        check("idle_mem_re", 32'(mem_re), 32'd0);

        push_frame();
        push_frame();
        enable = 1'b1;
        @(negedge clk);
        check("first_mem_re", 32'(mem_re), 32'd1);
        check("first_mem_addr", 32'(mem_addr), 32'd0);

        wait_fd(1, 300);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        wait_fd(2, 300);
        repeat (3) @(negedge clk);
        check("ev_q_drained", 32'(ev_q.size()), 32'd0);
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_after_frame", 32'({oe_n, mem_re, panel_clk, lat}), 32'b1000);
        end

        mon_en = 1'b0;
        enable = 1'b1;
        pc = 0;
        for (int i = 0; i < 50 && pc < 2; i++) begin
            @(negedge clk);
            if (panel_clk) pc++;
        end
        check("mid_shift_reached", 32'(pc), 32'd2);
        rst_n = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check_reset("mid_shift_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("quiet_after_reset", 32'({oe_n, mem_re, panel_clk, lat, frame_done}), 32'b10000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hub75_scan.md
HUB75_SCAN -- requirements
Module: hub75_scan

Interface
REQ-001 SHALL have parameter PANEL_COLS, default 64, columns per scan line (power of two, >=2).
REQ-002 SHALL have parameter ROW_BITS, default 5, scan-row address width (2**ROW_BITS rows per half-panel).
REQ-003 SHALL have parameter BCM_BITS, default 8, colour depth per channel (1..8).
REQ-004 SHALL have parameter BASE_CYCLES, default 4, clk cycles of display time for bitplane 0.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, start or continue frame scanning.
REQ-008 SHALL have port mem_re, output, 1, framebuffer read enable (connects to the BRAM read port).
REQ-009 SHALL have port mem_addr, output, ROW_BITS+log2(PANEL_COLS), read address {row, col}.
REQ-010 SHALL have port mem_dout, input, 64, read data, valid the cycle after mem_re; [23:0] upper pixel, [55:32] lower pixel, each R[23:16] G[15:8] B[7:0].
REQ-011 SHALL have ports r0 g0 b0 r1 g1 b1, output, 1 each, panel serial data, upper/lower halves.
REQ-012 SHALL have ports panel_clk, lat, oe_n, output, 1 each, panel shift clock, latch, active-low output enable.
REQ-013 SHALL have port row_addr, output, ROW_BITS, panel row select.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse at frame end.

Function
REQ-015 SHALL implement states IDLE, SHIFT, BLANK, LATCH, DISPLAY; IDLE->SHIFT when enable=1, row=0, bit=0.
REQ-016 SHALL in SHIFT, for column c (0..PANEL_COLS-1): assert mem_re with mem_addr={row,c} at cycle 2c, drive data = bit[bit] of each channel from cycle 2c+2, panel_clk=1 only at cycle 2c+3; SHIFT lasts 2*PANEL_COLS+2 cycles.
REQ-017 SHALL change rgb outputs only while panel_clk=0; exactly PANEL_COLS panel_clk pulses per SHIFT, each one cycle wide.
REQ-018 SHALL hold oe_n=1 for one cycle in BLANK, then assert lat=1 for one cycle in LATCH, updating row_addr to the current row in that same cycle.
REQ-019 SHALL hold oe_n=0 in DISPLAY for BASE_CYCLES<<bit cycles, then go to SHIFT of the next bitplane.
REQ-020 SHALL, after bit BCM_BITS-1, wrap bit to 0 and increment row; on row wrap from all-ones to 0, pulse frame_done in the first cycle of the next state.
REQ-021 SHALL, at frame end with enable=0, go to IDLE; deassertion of enable mid-frame SHALL NOT abort the frame.
REQ-022 SHALL keep oe_n=1 in every state except DISPLAY, and mem_re=0 outside SHIFT.

Reset
REQ-023 SHALL, when rst_n=0 at a clk edge, enter IDLE with oe_n=1, and lat, panel_clk, rgb, row_addr, mem_re, mem_addr, frame_done, bit, and row all 0.
REQ-024 SHALL apply reset identically in any state, including mid-SHIFT or mid-DISPLAY, with no further panel_clk or lat pulse.

Configuration
REQ-025 SHALL, with HUB75_BRIGHTNESS_EN defined, add input brightness[7:0]; in DISPLAY, oe_n=0 for the first ((BASE_CYCLES<<bit)*(brightness+1))>>8 cycles and 1 for the remainder of the unchanged slot length.
REQ-026 SHALL, without HUB75_BRIGHTNESS_EN, have no brightness port and keep oe_n=0 for the whole DISPLAY slot.

Verification (PANEL_COLS=4, ROW_BITS=1, BCM_BITS=2, BASE_CYCLES=2)
REQ-027 SHALL cover: reset release, enable=1 -> mem_re at cycle 0 with addr 0, 4 panel_clk pulses, lat pulse, oe_n low 2 cycles (bit0), then 4 (bit1).
REQ-028 SHALL cover: mem_dout upper R=0x02 for col 1 -> r0=0 on bitplane 0 and r0=1 on bitplane 1 during col 1's panel_clk pulse.
REQ-029 SHALL cover: two full rows -> row_addr 0 then 1, frame_done single pulse after row 1 bit 1, next frame starts at row 0.
REQ-030 SHALL cover: enable dropped during row 0 -> frame completes, then IDLE with oe_n=1.
REQ-031 SHALL cover: rst_n=0 mid-SHIFT -> next cycle all outputs at reset values, no lat pulse.
REQ-032 SHALL cover: with HUB75_BRIGHTNESS_EN and brightness=127, bit1 slot -> oe_n low 2 of 4 cycles.
